// File: rtl/cpu_io_pkg.sv
// Shared constants for the processor output-port path.
package cpu_io_pkg;

  localparam int unsigned OUT_DATA_W     = 16;
  localparam int unsigned OUT_FIFO_DEPTH = 4;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned occWidth(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/out_port_fifo_if.sv
// Consumer-side valid/ready handshake of the output-port FIFO.
interface out_port_fifo_if #(
  parameter int unsigned DATA_W = 16
);
  logic              port_valid;
  logic [DATA_W-1:0] port_data;
  logic              port_ready;

  modport master (output port_valid, output port_data, input port_ready);
  modport slave  (input port_valid, input port_data, output port_ready);
endinterface

// File: rtl/out_fifo_ram.sv
// DEPTH x DATA_W register array, synchronous write, asynchronous read.
module out_fifo_ram #(
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/out_port_fifo.sv
// Output-port buffer behind write-back: captures OUT results, drains them
// over valid/ready, and reports full to the hazard unit for stalling.
module out_port_fifo
  import cpu_io_pkg::*;
#(
  parameter  int unsigned DATA_W = OUT_DATA_W,
  parameter  int unsigned DEPTH  = OUT_FIFO_DEPTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = occWidth(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                out_en,
  input  logic [DATA_W-1:0]   out_data,
  output logic                full,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  output logic [DATA_W-1:0]   last_out,
  out_port_fifo_if.master     consumer
);

  logic [ADDR_W-1:0] wrPtr, rdPtr, wrNext, rdNext;
  logic [CNT_W-1:0]  cntNext;
  logic [DATA_W-1:0] headNext, ramRdata, headQ;
  logic              validQ, pop, push, drop;

  out_fifo_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) uRam (
    .clk   (clk),
    .we    (push),
    .waddr (wrPtr),
    .wdata (out_data),
    .raddr (rdNext),
    .rdata (ramRdata)
  );

  // Handshake decode and next-state pointer/count computation.
  always_comb begin
    pop     = validQ && consumer.port_ready;
    push    = out_en && (!full || pop);
    drop    = out_en && full && !pop;
    wrNext  = push ? wrPtr + ADDR_W'(1) : wrPtr;
    rdNext  = pop  ? rdPtr + ADDR_W'(1) : rdPtr;
    cntNext = count;
    if (push && !pop) cntNext = count + CNT_W'(1);
    if (pop && !push) cntNext = count - CNT_W'(1);
    // The next head is the incoming word when it lands at the new read slot.
    headNext = ramRdata;
    if (push && (wrPtr == rdNext)) headNext = out_data;
    if (cntNext == '0)             headNext = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      full     <= 1'b0;
      validQ   <= 1'b0;
      headQ    <= '0;
      overflow <= 1'b0;
      last_out <= '0;
    end else begin
      wrPtr    <= wrNext;
      rdPtr    <= rdNext;
      count    <= cntNext;
      full     <= (cntNext == CNT_W'(DEPTH));
      validQ   <= (cntNext != '0);
      headQ    <= headNext;
      if (drop) overflow <= 1'b1;
      if (push) last_out <= out_data;
    end
  end

  assign consumer.port_valid = validQ;
  assign consumer.port_data  = headQ;

endmodule
